// File: rtl/tim_fifo_ctrl.sv
// FIFO controller around a single-port 16x8 RAM with registered read data.
// Prefetch reads take the port ahead of writes and feed a one-word output register.
module tim_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          ram_e,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_pend_q, rd_pend_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic rd_go;
  logic wr_go;
  logic full_w;

  always_comb begin
    full_w = (count_q == FULL_CNT);
    // Only issue a read when the output register is guaranteed free at capture.
    rd_go  = (count_q != '0) && !rd_pend_q && (!out_valid_q || out_ready);
    wr_go  = in_valid && !full_w && !rd_go;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_pend_d   = rd_go;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;

    if (rd_go) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - (AW+1)'(1);
    end else if (wr_go) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + (AW+1)'(1);
    end

    // Capture wins over a pop on the same edge.
    if (rd_pend_q) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_do;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    ram_e     = rst_n && (rd_go || wr_go);
    ram_we    = rst_n && wr_go;
    ram_addr  = rd_go ? rd_ptr_q : wr_ptr_q;
    ram_di    = in_data;
    in_ready  = !full_w && !rd_go;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    count     = count_q;
    full      = full_w;
    empty     = (count_q == '0) && !out_valid_q;
  end

endmodule

// File: tb/tb_tim_fifo_ctrl.sv
// Self-checking bench for tim_fifo_ctrl: directed scenarios plus a random stream
// checked against an in-order queue model, with a behavioural 16x8 RAM attached.
module tb_tim_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       ram_e;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_di;
  logic [7:0] ram_do;
  logic [4:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  tim_fifo_ctrl #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_e(ram_e), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do), .count(count), .full(full), .empty(empty)
  );

  // Single-port RAM with registered read data.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_e) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        ram_do <= mem[ram_addr];
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h5C; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ram_e, ram_we} !== 2'b00) begin
      n_fails++; $display("FAIL reset_ram_e: got e=%b we=%b required 0 0", ram_e, ram_we);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++;
    if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_empty: got %b required 1", empty); end
    n_checks++;
    if (count !== 5'd0) begin n_fails++; $display("FAIL reset_count: got %0d required 0", count); end
    n_checks++;
    if (ram_e !== 1'b0) begin n_fails++; $display("FAIL reset_idle_ram_e: got %b required 0", ram_e); end
    n_checks++;
    if (full !== 1'b0) begin n_fails++; $display("FAIL reset_full: got %b required 0", full); end
    n_checks++;
    if (out_data !== 8'h00) begin n_fails++; $display("FAIL reset_out_data: got %h required 00", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_push3();
    logic [7:0] words [3];
    logic       exp_rdy [4];
    logic       exp_ov  [4];
    int         idx;
    words   = '{8'h11, 8'h22, 8'h33};
    exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_ov  = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = words[idx];
      @(negedge clk);
      n_checks++;
      if (in_ready !== exp_rdy[c]) begin
        n_fails++; $display("FAIL push3_in_ready[%0d]: got %b required %b", c, in_ready, exp_rdy[c]);
      end
      n_checks++;
      if (out_valid !== exp_ov[c]) begin
        n_fails++; $display("FAIL push3_out_valid[%0d]: got %b required %b", c, out_valid, exp_ov[c]);
      end
      if (in_ready && idx < 2) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_fails++; $display("FAIL push3_head: got v=%b d=%h required v=1 d=11", out_valid, out_data);
    end
    n_checks++;
    if (count !== 5'd2) begin n_fails++; $display("FAIL push3_count: got %0d required 2", count); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    int acc;
    do_reset();
    acc = 0;
    for (int c = 0; c < 200 && acc < 17; c++) begin
      in_valid = 1'b1; in_data = 8'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (acc !== 17) begin n_fails++; $display("FAIL fill_accepted: got %0d required 17", acc); end
    in_data = 8'h11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fails++; $display("FAIL fill_word18_held[%0d]: got %b required 0", c, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (full !== 1'b1) begin n_fails++; $display("FAIL fill_full: got %b required 1", full); end
    n_checks++;
    if (count !== 5'd16) begin n_fails++; $display("FAIL fill_count: got %0d required 16", count); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      n_fails++; $display("FAIL fill_head: got v=%b d=%h required v=1 d=00", out_valid, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drain();
    int   k;
    logic prev_ov;
    out_ready = 1'b1;
    k = 0;
    prev_ov = 1'b0;
    for (int c = 0; c < 80 && k < 17; c++) begin
      @(negedge clk);
      n_checks++;
      if ((out_valid && prev_ov) !== 1'b0) begin
        n_fails++; $display("FAIL drain_toggle[%0d]: got two valid cycles in a row required alternating", c);
      end
      if (out_valid) begin
        n_checks++;
        if (out_data !== 8'(k)) begin n_fails++; $display("FAIL drain_data[%0d]: got %h required %h", k, out_data, 8'(k)); end
        k++;
      end
      prev_ov = out_valid;
      @(posedge clk); #1;
    end
    n_checks++;
    if (k !== 17) begin n_fails++; $display("FAIL drain_words: got %0d required 17", k); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (empty !== 1'b1 || count !== 5'd0 || out_valid !== 1'b0) begin
      n_fails++; $display("FAIL drain_empty: got empty=%b count=%0d v=%b required 1 0 0", empty, count, out_valid);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [7:0] q [$];
    logic [7:0] exp_w;
    int pushed, popped, wr_i, rd_i, held;
    bit accepted;
    do_reset();
    pushed = 0; popped = 0; wr_i = 0; rd_i = 0;
    for (int c = 0; c < 3000 && popped < 40; c++) begin
      if (!in_valid && pushed < 40 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_data = 8'(pushed);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      accepted = 1'b0;
      held = pushed - popped;
      n_checks++;
      if (!(held - int'(count) - int'(out_valid) inside {0, 1})) begin
        n_fails++; $display("FAIL stream_occupancy: got count=%0d v=%b required held %0d", count, out_valid, held);
      end
      n_checks++;
      if (full !== (count == 5'd16) || (in_ready && full)) begin
        n_fails++; $display("FAIL stream_full: got full=%b in_ready=%b count=%0d", full, in_ready, count);
      end
      if (ram_e) begin
        n_checks++;
        if (ram_we && (ram_addr !== 4'(wr_i) || ram_di !== in_data)) begin
          n_fails++; $display("FAIL stream_wr_addr: got %0d/%h required %0d/%h", ram_addr, ram_di, 4'(wr_i), in_data);
        end else if (!ram_we && ram_addr !== 4'(rd_i)) begin
          n_fails++; $display("FAIL stream_rd_addr: got %0d required %0d", ram_addr, 4'(rd_i));
        end
        if (ram_we) wr_i++; else rd_i++;
      end
      if (out_valid && out_ready) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 8'hxx;
        n_checks++;
        if (out_data !== exp_w) begin n_fails++; $display("FAIL stream_data[%0d]: got %h required %h", popped, out_data, exp_w); end
        popped++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        pushed++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (popped !== 40) begin n_fails++; $display("FAIL stream_popped: got %0d required 40", popped); end
    n_checks++;
    if (wr_i !== 40 || rd_i !== 40) begin
      n_fails++; $display("FAIL stream_ram_ops: got wr=%0d rd=%0d required 40 40", wr_i, rd_i);
    end
  endtask

  task automatic test_reset_inflight();
    bit got;
    do_reset();
    in_valid = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("FAIL inflight_accept: got %b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ram_e, ram_we} !== 2'b10 || ram_addr !== 4'd0) begin
      n_fails++; $display("FAIL inflight_issue: got e=%b we=%b a=%0d required 1 0 0", ram_e, ram_we, ram_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      n_fails++; $display("FAIL inflight_discard: got v=%b count=%0d empty=%b required 0 0 1", out_valid, count, empty);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = out_valid;
      if (!got) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (got !== 1'b1 || out_data !== 8'hA5) begin
      n_fails++; $display("FAIL inflight_next_pop: got v=%b d=%h required v=1 d=a5", got, out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_push3();
    test_fill();
    test_drain();
    test_random_stream();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
